// File: rtl/io_hub_pkg.sv
// Shared definitions for the I/O hub controller: IPL encodings, interrupt
// level packing helpers and counter width helpers.
package io_hub_pkg;

  // 68000 IPL lines are active low; all ones means no interrupt pending
  localparam logic [2:0] IPL_NONE = 3'b111;

  // Largest number of interrupt sources the packing helpers handle
  localparam int MAX_IRQ = 16;
  localparam int LEVELS_W = 3 * MAX_IRQ;

  typedef logic [2:0] ipl_t;

  // Extract the 3-bit level of source idx from a packed level vector
  function automatic ipl_t level_of(input logic [LEVELS_W-1:0] levels,
                                    input int idx);
    return levels[3*idx +: 3];
  endfunction

  // Place a 3-bit level for source idx into a packed level vector
  function automatic logic [LEVELS_W-1:0] pack_level(input logic [LEVELS_W-1:0] levels,
                                                     input int idx,
                                                     input ipl_t level);
    logic [LEVELS_W-1:0] result;
    result = levels;
    result[3*idx +: 3] = level;
    return result;
  endfunction

  // Bits needed to hold values 0..max_count (at least one bit)
  function automatic int cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Interrupt priority encoder: synchronises active-low requests on the
// positive-phase enable and presents the highest asserted level as an
// active-low registered IPL code.
module irq_prio_enc
  import io_hub_pkg::*;
#(
  parameter int NUM_IRQ = 2,
  parameter logic [3*NUM_IRQ-1:0] IRQ_LEVELS = {3'd5, 3'd6}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cep,
  input  logic               hold,
  input  logic [NUM_IRQ-1:0] irq_n,
  output logic [2:0]         ipl_n
);

  localparam logic [LEVELS_W-1:0] LEVELS_EXT = LEVELS_W'(IRQ_LEVELS);

  logic [NUM_IRQ-1:0] sync1;
  logic [NUM_IRQ-1:0] sync2;
  logic [2:0]         level_max;
  logic [2:0]         lvl;

  // Two-flop synchroniser for the asynchronous request lines
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else if (cep) begin
      sync1 <= irq_n;
      sync2 <= sync1;
    end
  end

  // Highest level among asserted sources; a level of 0 never wins, so it disables the source
  always_comb begin
    level_max = 3'd0;
    lvl       = 3'd0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      lvl = level_of(LEVELS_EXT, i);
      if (!sync2[i] && (lvl > level_max)) begin
        level_max = lvl;
      end
    end
  end

  // Registered IPL output, held idle while the CPU is in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ipl_n <= IPL_NONE;
    end else if (hold) begin
      ipl_n <= IPL_NONE;
    end else if (cep) begin
      ipl_n <= ~level_max;
    end
  end

endmodule

// File: rtl/io_hub_ctrl.sv
// I/O hub controller: CPU reset stretching, interrupt level encoding,
// peripheral read-data steering and the PWM audio sample path with
// click-free volume ramping.
module io_hub_ctrl
  import io_hub_pkg::*;
#(
  parameter int                     NUM_PERIPH   = 4,
  parameter logic [NUM_PERIPH-1:0]  BYTE_MASK    = 4'b1100,
  parameter logic [7:0]             FILL_BYTE    = 8'hEF,
  parameter int                     NUM_IRQ      = 2,
  parameter logic [3*NUM_IRQ-1:0]   IRQ_LEVELS   = {3'd5, 3'd6},
  parameter int unsigned            RESET_CYCLES = 32'h000F_FFFF,
  parameter int                     SAMPLE_W     = 8,
  parameter int                     VOL_BITS     = 3,
  parameter int unsigned            RAMP_DIV     = 256
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cep,
  input  logic                         cen,
  input  logic                         soft_reset,
  output logic                         cpu_reset_n,
  output logic [2:0]                   cpu_ipl_n,
  input  logic [NUM_IRQ-1:0]           irq_n,
  input  logic [NUM_PERIPH-1:0]        sel,
  input  logic [16*NUM_PERIPH-1:0]     periph_rdata,
  input  logic [15:0]                  mem_rdata,
  output logic [15:0]                  cpu_rdata,
  input  logic                         load_sound,
  input  logic [VOL_BITS-1:0]          snd_vol,
  input  logic                         snd_mute,
  output logic [SAMPLE_W+VOL_BITS-1:0] audio_out
);

  localparam int RST_W = cnt_width(RESET_CYCLES);
  localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RESET_CYCLES);

  localparam int unsigned DIV_MAX = (RAMP_DIV == 0) ? 0 : RAMP_DIV - 1;
  localparam int DIV_W = cnt_width(DIV_MAX);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX);

  localparam int AUD_W = SAMPLE_W + VOL_BITS;

  logic [RST_W-1:0]    rst_count;
  logic [RST_W-1:0]    rst_count_next;
  logic                ipl_hold;
  logic                load_d;
  logic [SAMPLE_W-1:0] sample;
  logic [DIV_W-1:0]    ramp_div;
  logic [VOL_BITS-1:0] vol_cur;
  logic [AUD_W-1:0]    scaled;

  // Next reset-stretch count: a soft reset reloads, otherwise count down on cep
  always_comb begin
    rst_count_next = rst_count;
    if (soft_reset) begin
      rst_count_next = RST_LOAD;
    end else if (cep && (rst_count != '0)) begin
      rst_count_next = rst_count - RST_W'(1);
    end
  end

  // Reset-stretch counter; the CPU is released on the edge the count reaches zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rst_count   <= RST_LOAD;
      cpu_reset_n <= 1'b0;
    end else begin
      rst_count   <= rst_count_next;
      cpu_reset_n <= (rst_count_next == '0);
    end
  end

  assign ipl_hold = ~cpu_reset_n;

  irq_prio_enc #(
    .NUM_IRQ    (NUM_IRQ),
    .IRQ_LEVELS (IRQ_LEVELS)
  ) u_irq_prio_enc (
    .clk   (clk),
    .reset (reset),
    .cep   (cep),
    .hold  (ipl_hold),
    .irq_n (irq_n),
    .ipl_n (cpu_ipl_n)
  );

  // Read-data steering: the lowest selected peripheral wins, RAM/ROM otherwise
  always_comb begin
    cpu_rdata = mem_rdata;
    for (int i = NUM_PERIPH - 1; i >= 0; i--) begin
      if (sel[i]) begin
        if (BYTE_MASK[i]) begin
          cpu_rdata = {periph_rdata[16*i +: 8], FILL_BYTE};
        end else begin
          cpu_rdata = periph_rdata[16*i +: 16];
        end
      end
    end
  end

  // Sound-slot flag captured on the negative phase
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_d <= 1'b0;
    end else if (cen) begin
      load_d <= load_sound;
    end
  end

  // Audio sample latch, loaded on the positive phase after a sound slot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample <= '0;
    end else if (cep && load_d) begin
      sample <= snd_mute ? '0 : mem_rdata[15 -: SAMPLE_W];
    end
  end

  // Volume ramp: step one unit toward the target each time the divider wraps
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ramp_div <= '0;
      vol_cur  <= '0;
    end else if (cep) begin
      if (RAMP_DIV == 0) begin
        ramp_div <= '0;
        vol_cur  <= snd_vol;
      end else if (ramp_div == DIV_LAST) begin
        ramp_div <= '0;
        if (vol_cur < snd_vol) begin
          vol_cur <= vol_cur + VOL_BITS'(1);
        end else if (vol_cur > snd_vol) begin
          vol_cur <= vol_cur - VOL_BITS'(1);
        end
      end else begin
        ramp_div <= ramp_div + DIV_W'(1);
      end
    end
  end

  // Shift-and-add multiply of the sample by the current volume
  always_comb begin
    scaled = '0;
    for (int b = 0; b < VOL_BITS; b++) begin
      if (vol_cur[b]) begin
        scaled = scaled + (AUD_W'(sample) << b);
      end
    end
  end

  // Registered audio output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      audio_out <= '0;
    end else if (cep) begin
      audio_out <= scaled;
    end
  end

endmodule

// File: tb/tb_io_hub_ctrl.sv
// Scoreboard bench for io_hub_ctrl: stimulus queues expected values tagged
// with the cycle they are due; a monitor compares them on the falling edge.
module tb_io_hub_ctrl;

  typedef enum logic [2:0] {SIG_RST, SIG_IPL, SIG_RDATA, SIG_AUD0, SIG_AUD4} sig_e;

  typedef struct packed {
    logic [31:0] due;
    sig_e        sig;
    logic [15:0] exp;
  } exp_t;

  // Source 0 at level 5, source 1 at level 6
  localparam logic [5:0] TB_IRQ_LEVELS = {3'd6, 3'd5};

  localparam logic [3:0]  MUX_SEL [8] = '{4'b0100, 4'b0101, 4'b0000, 4'b0010,
                                          4'b1000, 4'b1100, 4'b1111, 4'b1010};
  localparam logic [15:0] MUX_EXP [8] = '{16'hA5EF, 16'hC0DE, 16'hBEEF, 16'h5A3C,
                                          16'h77EF, 16'hA5EF, 16'hC0DE, 16'h5A3C};

  localparam int          RAMP_OFS [14] = '{1, 4, 5, 8, 9, 12, 13, 16, 17, 20, 21, 24, 25, 33};
  localparam logic [15:0] RAMP_EXP [14] = '{16'h000, 16'h000, 16'h080, 16'h080, 16'h100,
                                            16'h100, 16'h180, 16'h180, 16'h200, 16'h200,
                                            16'h180, 16'h180, 16'h100, 16'h100};

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cep = 1'b1;
  logic        cen = 1'b1;
  logic        soft_reset = 1'b0;
  logic [1:0]  irq_n = 2'b11;
  logic [3:0]  sel = 4'b0000;
  logic [63:0] periph_rdata = '0;
  logic [15:0] mem_rdata = '0;
  logic        load_sound = 1'b0;
  logic [2:0]  snd_vol = 3'd0;
  logic        snd_mute = 1'b0;

  logic        cpu_reset_n_a, cpu_reset_n_b;
  logic [2:0]  cpu_ipl_n_a, cpu_ipl_n_b;
  logic [15:0] cpu_rdata_a, cpu_rdata_b;
  logic [10:0] audio_a, audio_b;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  io_hub_ctrl #(
    .IRQ_LEVELS   (TB_IRQ_LEVELS),
    .RESET_CYCLES (16),
    .RAMP_DIV     (0)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .cep          (cep),
    .cen          (cen),
    .soft_reset   (soft_reset),
    .cpu_reset_n  (cpu_reset_n_a),
    .cpu_ipl_n    (cpu_ipl_n_a),
    .irq_n        (irq_n),
    .sel          (sel),
    .periph_rdata (periph_rdata),
    .mem_rdata    (mem_rdata),
    .cpu_rdata    (cpu_rdata_a),
    .load_sound   (load_sound),
    .snd_vol      (snd_vol),
    .snd_mute     (snd_mute),
    .audio_out    (audio_a)
  );

  io_hub_ctrl #(
    .IRQ_LEVELS   (TB_IRQ_LEVELS),
    .RESET_CYCLES (16),
    .RAMP_DIV     (4)
  ) u_dut_ramp (
    .clk          (clk),
    .reset        (reset),
    .cep          (cep),
    .cen          (cen),
    .soft_reset   (soft_reset),
    .cpu_reset_n  (cpu_reset_n_b),
    .cpu_ipl_n    (cpu_ipl_n_b),
    .irq_n        (irq_n),
    .sel          (sel),
    .periph_rdata (periph_rdata),
    .mem_rdata    (mem_rdata),
    .cpu_rdata    (cpu_rdata_b),
    .load_sound   (load_sound),
    .snd_vol      (snd_vol),
    .snd_mute     (snd_mute),
    .audio_out    (audio_b)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expectations
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compare every expectation that falls due in this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (int'(sb[i].due) == cyc) begin
        case (sb[i].sig)
          SIG_RST: begin
            compare("cpu_reset_n dut0", 16'(cpu_reset_n_a), sb[i].exp);
            compare("cpu_reset_n dut1", 16'(cpu_reset_n_b), sb[i].exp);
          end
          SIG_IPL: begin
            compare("cpu_ipl_n dut0", 16'(cpu_ipl_n_a), sb[i].exp);
            compare("cpu_ipl_n dut1", 16'(cpu_ipl_n_b), sb[i].exp);
          end
          SIG_RDATA: begin
            compare("cpu_rdata dut0", cpu_rdata_a, sb[i].exp);
            compare("cpu_rdata dut1", cpu_rdata_b, sb[i].exp);
          end
          SIG_AUD0: compare("audio_out ramp0", 16'(audio_a), sb[i].exp);
          default:  compare("audio_out ramp4", 16'(audio_b), sb[i].exp);
        endcase
        sb.delete(i);
      end
    end
  end

  // Advance to the drive slot just after the n-th next rising edge
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue an expected value due offset cycles from now
  task automatic checkOutput(input sig_e sig, input int offset, input logic [15:0] exp);
    exp_t e;
    e.due = 32'(cyc + offset);
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  initial begin
    int base;

    // Reset state
    applyStimulus(1);
    checkOutput(SIG_RST, 0, 16'h0);
    checkOutput(SIG_IPL, 0, 16'h7);
    checkOutput(SIG_AUD0, 0, 16'h0);
    checkOutput(SIG_AUD4, 0, 16'h0);

    // Reset stretch with a soft reset when the count reaches 5
    applyStimulus(1);
    reset = 1'b0;
    for (int k = 0; k < 28; k++) checkOutput(SIG_RST, k, 16'h0);
    checkOutput(SIG_RST, 28, 16'h1);
    checkOutput(SIG_RST, 30, 16'h1);
    applyStimulus(2);
    irq_n = 2'b00;
    checkOutput(SIG_IPL, 8, 16'h7);
    applyStimulus(8);
    irq_n = 2'b11;
    applyStimulus(1);
    soft_reset = 1'b1;
    applyStimulus(1);
    soft_reset = 1'b0;
    applyStimulus(18);

    // Read-data steering
    periph_rdata = {16'h9977, 16'h12A5, 16'h5A3C, 16'hC0DE};
    mem_rdata = 16'hBEEF;
    for (int v = 0; v < 8; v++) begin
      sel = MUX_SEL[v];
      checkOutput(SIG_RDATA, 0, MUX_EXP[v]);
      applyStimulus(1);
    end
    sel = 4'b0000;

    // Interrupt encoding, including a stalled positive-phase enable
    cep = 1'b0;
    irq_n = 2'b10;
    checkOutput(SIG_IPL, 1, 16'h7);
    checkOutput(SIG_IPL, 3, 16'h7);
    checkOutput(SIG_IPL, 5, 16'h7);
    applyStimulus(5);
    cep = 1'b1;
    checkOutput(SIG_IPL, 2, 16'h7);
    checkOutput(SIG_IPL, 3, 16'h2);
    applyStimulus(5);
    irq_n = 2'b00;
    checkOutput(SIG_IPL, 2, 16'h2);
    checkOutput(SIG_IPL, 3, 16'h1);
    applyStimulus(5);
    irq_n = 2'b01;
    checkOutput(SIG_IPL, 3, 16'h1);
    applyStimulus(5);
    irq_n = 2'b11;
    checkOutput(SIG_IPL, 2, 16'h1);
    checkOutput(SIG_IPL, 3, 16'h7);
    applyStimulus(5);

    // Volume ramp from a fresh reset: 0 -> 5, redirected to 2 at level 4
    reset = 1'b1;
    snd_vol = 3'd5;
    mem_rdata = 16'h8000;
    load_sound = 1'b1;
    snd_mute = 1'b0;
    applyStimulus(1);
    reset = 1'b0;
    for (int k = 0; k < 14; k++) checkOutput(SIG_AUD4, RAMP_OFS[k], RAMP_EXP[k]);
    checkOutput(SIG_AUD0, 1, 16'h000);
    checkOutput(SIG_AUD0, 2, 16'h000);
    checkOutput(SIG_AUD0, 3, 16'h280);
    applyStimulus(17);
    snd_vol = 3'd2;
    checkOutput(SIG_AUD0, 1, 16'h280);
    checkOutput(SIG_AUD0, 2, 16'h100);
    applyStimulus(17);

    // Sample latch, load slots, mute and full-scale product
    base = cyc;
    load_sound = 1'b0;
    snd_vol = 3'd7;
    checkOutput(SIG_AUD0, 2, 16'h380);
    applyStimulus(2);
    mem_rdata = 16'hFF00;
    checkOutput(SIG_AUD0, 3, 16'h380);
    applyStimulus(3);
    load_sound = 1'b1;
    mem_rdata = 16'h4000;
    applyStimulus(1);
    load_sound = 1'b0;
    checkOutput(SIG_AUD0, 1, 16'h380);
    checkOutput(SIG_AUD0, 2, 16'h1C0);
    applyStimulus(4);
    snd_mute = 1'b1;
    load_sound = 1'b1;
    applyStimulus(1);
    load_sound = 1'b0;
    checkOutput(SIG_AUD0, 1, 16'h1C0);
    checkOutput(SIG_AUD0, 2, 16'h000);
    applyStimulus(4);
    snd_mute = 1'b0;
    mem_rdata = 16'hFF00;
    load_sound = 1'b1;
    applyStimulus(1);
    load_sound = 1'b0;
    checkOutput(SIG_AUD0, 2, 16'h6F9);
    applyStimulus(5);
    $display("[TB] audio phase spanned %0d cycles", cyc - base);

    // Drain the scoreboard within a bounded number of cycles
    for (int t = 0; t < 50 && sb.size() != 0; t++) applyStimulus(1);
    while (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL expectation never sampled: due %0d, got none, expected %h",
               sb[0].due, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_hub_ctrl.md
Name: io_hub_ctrl

Overview:
- Parametrised successor of the system data controller.
- Holds the glue logic that sits between the 68000 core, the RAM/ROM path and the peripheral cores (VIA, IWM, SCC, SCSI and future additions).
- Generalises four functions: CPU reset stretching, the priority interrupt encoder, the peripheral read-data mux and the PWM-sample audio latch.
- Adds a programmable interrupt level per source, a soft-reset request and click-free volume ramping.

Parameters:
NUM_PERIPH, 4, number of peripheral read ports; index 0 has highest select priority
BYTE_MASK, 4'b1100, bit i set = peripheral i is byte-wide; only its rdata[7:0] is valid
FILL_BYTE, 8'hEF, filler driven on the low lane for byte-wide peripherals
NUM_IRQ, 2, number of active-low interrupt sources
IRQ_LEVELS, {3'd5,3'd6}, packed 3-bit IPL level per source (source i at bits 3i+2:3i)
RESET_CYCLES, 20'hFFFFF, cep pulses cpu_reset_n is held low after any reset event
SAMPLE_W, 8, audio sample width, taken from mem_rdata[15:16-SAMPLE_W]
VOL_BITS, 3, volume control width
RAMP_DIV, 256, cep pulses per volume step; 0 = volume applied immediately

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cep  in  1  positive-phase clock enable
cen  in  1  negative-phase clock enable
soft_reset  in  1  synchronous request to restart the CPU reset stretch
cpu_reset_n  out  1  68000 RESET/HALT, active low
cpu_ipl_n  out  3  68000 IPL2..0, active low
irq_n  in  NUM_IRQ  peripheral interrupt requests, active low, asynchronous
sel  in  NUM_PERIPH  peripheral select strobes
periph_rdata  in  16*NUM_PERIPH  packed peripheral read data
mem_rdata  in  16  RAM/ROM read data
cpu_rdata  out  16  data to CPU
load_sound  in  1  sound-fetch slot indicator from the memory controller
snd_vol  in  VOL_BITS  target volume
snd_mute  in  1  1 = audio output forced to zero
audio_out  out  SAMPLE_W+VOL_BITS  scaled audio

Behaviour:
- Reset (async, reset=1):
  - counter = RESET_CYCLES, cpu_reset_n=0
  - cpu_ipl_n=3'b111, irq synchronisers all 1
  - sample latch=0, vol_cur=0, ramp divider=0, audio_out=0
- Reset stretch:
  - On each cep with counter!=0, counter decrements.
  - cpu_reset_n = (counter==0), registered.
  - soft_reset=1 on any clk edge reloads RESET_CYCLES, including mid-count.
- Interrupts:
  - Each irq_n bit passes through a 2-flop synchroniser clocked on cep.
  - Combinational max of IRQ_LEVELS over asserted sources, registered on cep.
  - cpu_ipl_n = ~max; 3'b111 when none are asserted.
  - Latency: assertion to cpu_ipl_n is 3 cep pulses.
  - Equal levels merge without error; level 0 in IRQ_LEVELS disables that source.
  - While cpu_reset_n=0, the registered IPL is forced to 3'b111.
- Read mux (combinational):
  - Lowest asserted sel index wins.
  - Byte-wide peripheral i returns {rdata_i[7:0], FILL_BYTE}; word-wide returns rdata_i[15:0].
  - No sel asserted returns mem_rdata.
  - Multiple sel asserted is legal; priority decides.
- Audio latch:
  - load_sound is captured into load_d on cen.
  - On the following cep with load_d=1, sample <= snd_mute ? 0 : mem_rdata[15:16-SAMPLE_W].
  - Back-to-back load slots reload each cep.
- Volume ramp:
  - RAMP_DIV=0: vol_cur=snd_vol on every cep.
  - Otherwise the divider counts cep pulses and wraps at RAMP_DIV-1.
  - On wrap, vol_cur moves one step toward snd_vol; no overshoot, no change when equal.
  - A target change mid-ramp redirects from the current value.
- audio_out:
  - audio_out = Σ over bits b of vol_cur: (vol_cur[b] ? sample<<b : 0).
  - Zero-extended to SAMPLE_W+VOL_BITS; registered on cep.
  - Maximum value (2^VOL_BITS-1)*(2^SAMPLE_W-1) always fits, so no overflow.

Decomposition:
- Package io_hub_pkg holds:
  - IPL encoding constants (IPL_NONE=3'b111)
  - the level-packing helper function
  - $clog2-based counter width helpers
- One natural sub-module, irq_prio_enc: synchroniser plus max-level encoder, parametrised by NUM_IRQ and IRQ_LEVELS, reusable for a future SCC/VIA expansion.

Test Plan:
- reset pulse, RESET_CYCLES=16, cep every cycle -> cpu_reset_n low exactly 16 cep, then high; soft_reset at count 5 -> low again for 16 more.
- irq_n=2'b10 (source0, level 5) -> cpu_ipl_n=3'b010 after 3 cep; add source1 (level 6) -> 3'b001; release both -> 3'b111.
- sel=4'b0100 with periph2 rdata=16'h12A5 -> cpu_rdata=16'hA5EF; sel=4'b0101 -> periph0 data; sel=0 -> mem_rdata.
- mem_rdata=16'h8000, snd_vol=7, RAMP_DIV=0, load slot -> audio_out=11'h380 (0x80*7); snd_mute=1 at next slot -> 0.
- RAMP_DIV=4, vol 0->5 -> vol_cur 1..5 stepping every 4 cep; target changed to 2 when vol_cur=4 -> steps 3, 2, then holds.
